// File: rtl/pipe_chain.sv
// Linear valid/data pipeline with per-stage stall and flush requests,
// plus saturating stall/flush/retire event counters.
module pipe_chain #(
    parameter  int DATA_W = 32,
    parameter  int STAGES = 4,
    parameter  int CNT_W  = 16,
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic [STAGES-1:0]        stall_vec,
    input  logic [STAGES-1:0]        flush_vec,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*DATA_W-1:0] stage_data,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [OCC_W-1:0]         occupancy,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt,
    output logic [CNT_W-1:0]         retire_cnt
);

    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;
    logic [STAGES-1:0]             shv;
    logic [STAGES-1:0][DATA_W-1:0] shd;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, retire_cnt_q;
    int   h, f;
    logic stall_hi, flush_apply, stall_apply, last_held, retire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        h = 0;
        f = 0;
        for (int i = 0; i < STAGES; i++) begin
            if (stall_vec[i]) h = i;
            if (flush_vec[i]) f = i;
        end
    end

    // A flush is deferred while any stage at or above the flusher is held.
    always_comb begin
        stall_hi = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (stall_vec[i] && i >= f) stall_hi = 1'b1;
        end
    end

    assign flush_apply = (|flush_vec) && !stall_hi;
    assign stall_apply = (|stall_vec) && !flush_apply;
    assign last_held   = stall_apply && (h == STAGES - 1);
    assign retire      = valid_q[STAGES-1] && !last_held;

    assign shv = {valid_q[STAGES-2:0], in_valid};
    assign shd = {data_q[STAGES-2:0], in_data};

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < STAGES; i++) begin
            if (flush_apply) begin
                if (i <= f) begin
                    valid_d[i] = 1'b0;
                    data_d[i]  = '0;
                end else begin
                    valid_d[i] = shv[i];
                    data_d[i]  = shd[i];
                end
            end else if (stall_apply) begin
                if (i == h + 1) begin
                    valid_d[i] = 1'b0;
                    data_d[i]  = '0;
                end else if (i > h + 1) begin
                    valid_d[i] = shv[i];
                    data_d[i]  = shd[i];
                end
            end else begin
                valid_d[i] = shv[i];
                data_d[i]  = shd[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q      <= '0;
            data_q       <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else if (en) begin
            valid_q <= valid_d;
            data_q  <= data_d;
            if (stall_apply) stall_cnt_q  <= sat_inc(stall_cnt_q);
            if (flush_apply) flush_cnt_q  <= sat_inc(flush_cnt_q);
            if (retire)      retire_cnt_q <= sat_inc(retire_cnt_q);
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + {{(OCC_W-1){1'b0}}, valid_q[i]};
        end
    end

    assign in_ready    = ~(|stall_vec);
    assign stage_valid = valid_q;
    assign stage_data  = data_q;
    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[STAGES-1];
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Directed vector bench for pipe_chain (STAGES=4, DATA_W=32),
// with a CNT_W=2 twin for counter saturation.
module tb_pipe_chain;

    logic        clk = 1'b0;
    logic        rst, en, in_valid;
    logic [31:0] in_data;
    logic [3:0]  stall_vec, flush_vec;
    logic        in_ready, out_valid;
    logic [3:0]  stage_valid;
    logic [127:0] stage_data;
    logic [31:0] out_data;
    logic [2:0]  occupancy;
    logic [15:0] stall_cnt, flush_cnt, retire_cnt;

    logic        in_ready2, out_valid2;
    logic [3:0]  stage_valid2;
    logic [127:0] stage_data2;
    logic [31:0] out_data2;
    logic [2:0]  occupancy2;
    logic [1:0]  stall_cnt2, flush_cnt2, retire_cnt2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_chain #(.DATA_W(32), .STAGES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .stall_vec(stall_vec), .flush_vec(flush_vec),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .out_valid(out_valid), .out_data(out_data), .occupancy(occupancy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
    );

    pipe_chain #(.DATA_W(32), .STAGES(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .stall_vec(stall_vec), .flush_vec(flush_vec),
        .stage_valid(stage_valid2), .stage_data(stage_data2),
        .out_valid(out_valid2), .out_data(out_data2), .occupancy(occupancy2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2), .retire_cnt(retire_cnt2)
    );

    typedef struct {
        logic        rst, en, iv;
        logic [31:0] id;
        logic [3:0]  st, fl;
        logic [3:0]  ev;
        logic [31:0] eo, e0;
        int          sc, fc, rc;
    } vec_t;

    localparam int NV = 30;
    vec_t tbl[NV];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        // rst en iv data st fl | valid out s0 sc fc rc
        tbl[0]  = '{0,1,1,32'hFFFF_FFFF,4'h0,4'h0, 4'b0000,32'h0,32'h0, 0,0,0};
        tbl[1]  = '{0,1,1,32'hFFFF_FFFF,4'hF,4'hF, 4'b0000,32'h0,32'h0, 0,0,0};
        tbl[2]  = '{1,1,1,32'hA0,4'h0,4'h0, 4'b0001,32'h0, 32'hA0, 0,0,0};
        tbl[3]  = '{1,1,1,32'hA1,4'h0,4'h0, 4'b0011,32'h0, 32'hA1, 0,0,0};
        tbl[4]  = '{1,1,1,32'hA2,4'h0,4'h0, 4'b0111,32'h0, 32'hA2, 0,0,0};
        tbl[5]  = '{1,1,1,32'hA3,4'h0,4'h0, 4'b1111,32'hA0,32'hA3, 0,0,0};
        tbl[6]  = '{1,1,1,32'hA4,4'h0,4'h0, 4'b1111,32'hA1,32'hA4, 0,0,1};
        tbl[7]  = '{1,1,1,32'hA5,4'h0,4'h0, 4'b1111,32'hA2,32'hA5, 0,0,2};
        tbl[8]  = '{1,1,0,32'h0, 4'h0,4'h0, 4'b1110,32'hA3,32'h0,  0,0,3};
        tbl[9]  = '{1,1,0,32'h0, 4'h0,4'h0, 4'b1100,32'hA4,32'h0,  0,0,4};
        tbl[10] = '{1,1,0,32'h0, 4'h0,4'h0, 4'b1000,32'hA5,32'h0,  0,0,5};
        tbl[11] = '{1,1,0,32'h0, 4'h0,4'h0, 4'b0000,32'h0, 32'h0,  0,0,6};
        tbl[12] = '{1,1,1,32'hD3,4'h0,4'h0, 4'b0001,32'h0, 32'hD3, 0,0,6};
        tbl[13] = '{1,1,1,32'hD2,4'h0,4'h0, 4'b0011,32'h0, 32'hD2, 0,0,6};
        tbl[14] = '{1,1,1,32'hD1,4'h0,4'h0, 4'b0111,32'h0, 32'hD1, 0,0,6};
        tbl[15] = '{1,1,1,32'hD0,4'h0,4'h0, 4'b1111,32'hD3,32'hD0, 0,0,6};
        tbl[16] = '{1,1,1,32'hEE,4'h2,4'h0, 4'b1011,32'hD2,32'hD0, 1,0,7};
        tbl[17] = '{1,1,1,32'hEE,4'h2,4'h0, 4'b0011,32'h0, 32'hD0, 2,0,8};
        tbl[18] = '{1,1,1,32'hE0,4'h0,4'h0, 4'b0111,32'h0, 32'hE0, 2,0,8};
        tbl[19] = '{1,1,1,32'hE1,4'h0,4'h0, 4'b1111,32'hD1,32'hE1, 2,0,8};
        tbl[20] = '{1,1,1,32'h99,4'h0,4'h4, 4'b1000,32'hD0,32'h0,  2,1,9};
        tbl[21] = '{1,1,1,32'h55,4'h8,4'h4, 4'b1000,32'hD0,32'h0,  3,1,9};
        tbl[22] = '{1,1,1,32'h66,4'h0,4'h4, 4'b0000,32'h0, 32'h0,  3,2,10};
        tbl[23] = '{1,1,1,32'h71,4'h0,4'h0, 4'b0001,32'h0, 32'h71, 3,2,10};
        tbl[24] = '{1,1,1,32'h72,4'h0,4'h0, 4'b0011,32'h0, 32'h72, 3,2,10};
        tbl[25] = '{1,0,1,32'h73,4'h1,4'h8, 4'b0011,32'h0, 32'h72, 3,2,10};
        tbl[26] = '{1,0,1,32'h73,4'h1,4'h8, 4'b0011,32'h0, 32'h72, 3,2,10};
        tbl[27] = '{1,0,1,32'h73,4'h1,4'h8, 4'b0011,32'h0, 32'h72, 3,2,10};
        tbl[28] = '{1,1,0,32'h0, 4'h0,4'h0, 4'b0110,32'h0, 32'h0,  3,2,10};
        tbl[29] = '{0,1,1,32'hAB,4'h2,4'h1, 4'b0000,32'h0, 32'h0,  0,0,0};

        rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0;
        stall_vec = '0; flush_vec = '0;
        @(posedge clk); #1;

        for (int k = 0; k < NV; k++) begin
            rst       = tbl[k].rst;
            en        = tbl[k].en;
            in_valid  = tbl[k].iv;
            in_data   = tbl[k].id;
            stall_vec = tbl[k].st;
            flush_vec = tbl[k].fl;
            #1;
            chk($sformatf("in_ready[%0d]", k), 64'(in_ready),
                64'(tbl[k].st == 4'h0));
            @(posedge clk); #1;
            chk($sformatf("valid[%0d]", k), 64'(stage_valid), 64'(tbl[k].ev));
            chk($sformatf("out_valid[%0d]", k), 64'(out_valid),
                64'(tbl[k].ev[3]));
            chk($sformatf("out_data[%0d]", k), 64'(out_data), 64'(tbl[k].eo));
            chk($sformatf("s0[%0d]", k), 64'(stage_data[31:0]),
                64'(tbl[k].e0));
            chk($sformatf("occ[%0d]", k), 64'(occupancy),
                64'($countones(tbl[k].ev)));
            chk($sformatf("stall_cnt[%0d]", k), 64'(stall_cnt),
                64'(tbl[k].sc));
            chk($sformatf("flush_cnt[%0d]", k), 64'(flush_cnt),
                64'(tbl[k].fc));
            chk($sformatf("retire_cnt[%0d]", k), 64'(retire_cnt),
                64'(tbl[k].rc));
            if (k == 17) begin
                chk("stall_s1_hold", 64'(stage_data[63:32]), 64'h0D1);
                chk("stall_s2_bubble", 64'(stage_data[95:64]), 64'h0);
            end
            if (k == 26) begin
                chk("en0_s1_hold", 64'(stage_data[63:32]), 64'h71);
            end
        end

        // Saturation: five applied stalls after reset.
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0;
        stall_vec = 4'b0001; flush_vec = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("sat_cnt16", 64'(stall_cnt), 64'd5);
        chk("sat_cnt2", 64'(stall_cnt2), 64'd3);
        stall_vec = '0;
        @(posedge clk); #1;
        chk("sat_cnt2_hold", 64'(stall_cnt2), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning per-stage payload width in bits.
REQ-002 SHALL have parameter STAGES, default 4, meaning the number of pipeline stages, legal range 2..8.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of each event counter.
REQ-004 SHALL have port clk  input  1  system clock; one clock domain only.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port en  input  1  global enable; when low, all state holds.
REQ-007 SHALL have port in_valid  input  1  a payload is presented to stage 0.
REQ-008 SHALL have port in_data  input  DATA_W  payload presented to stage 0.
REQ-009 SHALL have port in_ready  output  1  combinational; equals the NOR of all stall_vec bits.
REQ-010 SHALL have port stall_vec  input  STAGES  bit i is a hold request from stage i.
REQ-011 SHALL have port flush_vec  input  STAGES  bit i is a redirect request from the entry in stage i; it kills all younger entries.
REQ-012 SHALL have port stage_valid  output  STAGES  registered valid bit of each stage.
REQ-013 SHALL have port stage_data  output  STAGES*DATA_W  registered payloads; stage i occupies bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have port out_valid / out_data  output  1 / DATA_W  the valid bit and payload of stage STAGES-1.
REQ-015 SHALL have port occupancy  output  clog2(STAGES+1)  combinational count of set stage_valid bits.
REQ-016 SHALL have port stall_cnt, flush_cnt, retire_cnt  output  CNT_W each  registered event counters.

Function
REQ-017 SHALL define the following terms, each evaluated only on a posedge where en=1 and rst=1:
- h = index of the highest set stall_vec bit.
- f = index of the highest set flush_vec bit.
REQ-018 SHALL, with no stall and no flush, shift every stage:
- stage i+1 <= stage i (valid and data);
- stage 0 <= {in_valid, in_data}.
REQ-019 SHALL apply a stall when any stall_vec bit is set and no flush applies:
- stages 0..h hold;
- stage h+1 (if it exists) loads a bubble (valid=0, data=0);
- stages above h+1 shift normally;
- in_data is not captured.
REQ-020 SHALL apply a flush only if no stall_vec bit at index >= f is set. When applied:
- stages 0..f load valid=0, data=0;
- stage f+1 <= stage f;
- stages above shift normally;
- stall_vec bits below f are ignored;
- in_data is dropped.
REQ-021 SHALL ignore a flush when a stall_vec bit at index >= f is set: the stall rule alone applies and the requester holds flush_vec asserted.
REQ-022 SHALL have latency: a payload captured into stage 0 at edge k appears on out_data at edge k+STAGES-1, provided there is no stall.
REQ-023 SHALL count events on each enabled edge:
- stall_cnt increments when a stall applied;
- flush_cnt increments when a flush applied;
- retire_cnt increments when out_valid=1 and the last stage is not held.
REQ-024 SHALL saturate every counter at all-ones with no wrap.
REQ-025 SHALL, when en=0, hold every stage and counter regardless of stall_vec, flush_vec and in_valid.
REQ-026 SHALL treat a stall at index STAGES-1 as holding the whole chain, with no bubble and no retire.

Reset
REQ-027 SHALL, on a posedge with rst=0, regardless of en:
- clear all stage_valid bits and stage_data to 0;
- clear all counters to 0.
REQ-028 SHALL therefore hold out_valid=0, out_data=0 and occupancy=0 while in reset.
REQ-029 SHALL give reset priority over en, stall and flush, including when reset is asserted mid-stream.

Verification (STAGES=4, DATA_W=32)
REQ-030 SHALL cover reset: rst=0 for 2 cycles with in_valid=1, in_data=0xFFFF_FFFF -> stage_valid=0000, occupancy=0, all counters=0.
REQ-031 SHALL cover streaming: 0xA0..0xA5 on consecutive edges with no stall -> out_data=0xA0 exactly 3 edges after 0xA0 is captured, then 0xA1..0xA5 on successive edges; retire_cnt=6.
REQ-032 SHALL cover a stall: full chain {s3..s0}={D3,D2,D1,D0}, stall_vec=0010 for 2 edges ->
- s0=D0 and s1=D1 hold;
- after edge 1: s2 is a bubble, s3=D2;
- after edge 2: s3 is a bubble;
- stall_cnt=2, in_ready=0 during the stall.
REQ-033 SHALL cover a flush: full chain, flush_vec=0100 for one edge -> stage_valid=1000, out_data=old s2 payload, flush_cnt=1.
REQ-034 SHALL cover a deferred flush: stall_vec=1000 with flush_vec=0100 -> all stages hold, flush_cnt unchanged; on the next edge, stall released and flush still asserted -> flush applies, flush_cnt=1.
REQ-035 SHALL cover enable and saturation:
- en=0 for 3 edges mid-stream -> all outputs unchanged;
- CNT_W=2 with 5 stall edges -> stall_cnt=3.
